regfile_mp_sb: RTL and testbench

Parametrised multi-read-port register file for the processor datapath, the next generation of the 2-read/1-write regfile. Adds a configurable read-port count, an optional hardwired-zero register 0, write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequential clear engine that zeroes every entry after reset or on request. Sits between the decode stage (reads, reserves) and the writeback stage (writes).

---
 rtl/regfile_mp_sb.sv | 111 +++++++++++
 tb/tb_regfile_mp_sb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write bypass, per-register pending scoreboard
// and a sequential clear engine that zeroes every entry after reset or on request.
`timescale 1ns/1ps
module regfile_mp_sb #(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int NUM_READ_PORTS         = 2,
  parameter int ZERO_REG               = 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         clear_i,
  output logic                                         ready_o,
  input  logic                                         write_en_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0]            write_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]                   write_data_i,
  input  logic                                         rsv_en_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0]            rsv_addr_i,
  input  logic [NUM_READ_PORTS*PROC_REGFILE_LOG2_DEEP-1:0] read_addr_i,
  output logic [NUM_READ_PORTS*PROC_DATA_WIDTH-1:0]    read_data_o,
  output logic [NUM_READ_PORTS-1:0]                    read_pend_o
);

  localparam int DW    = PROC_DATA_WIDTH;
  localparam int AW    = PROC_REGFILE_LOG2_DEEP;
  localparam int DEPTH = 2**AW;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             wr_eff, rsv_eff;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_wdata;

  // Entry 0 swallows writes and reserves when it is the hardwired zero register.
  assign wr_eff  = ready_q && write_en_i && !((ZERO_REG != 0) && (write_addr_i == '0));
  assign rsv_eff = ready_q && rsv_en_i   && !((ZERO_REG != 0) && (rsv_addr_i == '0));
  assign ready_o = ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_waddr = write_addr_i;
    mem_wdata = write_data_i;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: begin
        mem_we = wr_eff;
        if (wr_eff)  pend_d[write_addr_i] = 1'b0;
        // Reserve applied after the write so a same-address pair leaves the bit set.
        if (rsv_eff) pend_d[rsv_addr_i] = 1'b1;
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          hit;

    assign ra      = read_addr_i[gi*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit     = wr_eff && (ra == write_addr_i);

    assign read_data_o[gi*DW +: DW] = (!ready_q || is_zero) ? '0 :
                                      hit                   ? write_data_i :
                                                              mem_q[ra];
    // Data arriving this cycle resolves the hazard, so a bypass hides the pending bit.
    assign read_pend_o[gi] = ready_q && pend_q[ra] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: a default build (2 ports, zero reg) and a
// 4-port build with ordinary entry 0 share stimulus; expected reads are queued and popped.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear, we, rsv;
  logic [AW-1:0] waddr, rsv_addr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] ra [4];
  logic [2*AW-1:0] rd_addr2;
  logic [4*AW-1:0] rd_addr4;
  logic [2*DW-1:0] rd_data2;
  logic [4*DW-1:0] rd_data4;
  logic [1:0]      pend2;
  logic [3:0]      pend4;
  logic            rdy_a, rdy_b;

  assign rd_addr2 = {ra[1], ra[0]};
  assign rd_addr4 = {ra[3], ra[2], ra[1], ra[0]};

  regfile_mp_sb dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .ready_o(rdy_a),
    .write_en_i(we), .write_addr_i(waddr), .write_data_i(wdata),
    .rsv_en_i(rsv), .rsv_addr_i(rsv_addr),
    .read_addr_i(rd_addr2), .read_data_o(rd_data2), .read_pend_o(pend2)
  );

  regfile_mp_sb #(.NUM_READ_PORTS(4), .ZERO_REG(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .ready_o(rdy_b),
    .write_en_i(we), .write_addr_i(waddr), .write_data_i(wdata),
    .rsv_en_i(rsv), .rsv_addr_i(rsv_addr),
    .read_addr_i(rd_addr4), .read_data_o(rd_data4), .read_pend_o(pend4)
  );

  typedef struct {
    string         name;
    int            inst;
    int            port;
    logic [DW-1:0] data;
    logic          pend;
  } exp_t;

  exp_t          sb [$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model_mem [DEPTH];

  function automatic logic [DW-1:0] obs_data(input int inst, input int port);
    if (inst == 0) return rd_data2[port*DW +: DW];
    return rd_data4[port*DW +: DW];
  endfunction

  function automatic logic obs_pend(input int inst, input int port);
    if (inst == 0) return pend2[port];
    return pend4[port];
  endfunction

  task automatic exp_rd(input string n, input int port, input logic [DW-1:0] da, input logic pa,
                        input logic [DW-1:0] db, input logic pb);
    if (port < 2) sb.push_back('{name: n, inst: 0, port: port, data: da, pend: pa});
    sb.push_back('{name: n, inst: 1, port: port, data: db, pend: pb});
  endtask

  task automatic exp_same(input string n, input int port, input logic [DW-1:0] d, input logic p);
    exp_rd(n, port, d, p, d, p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv = 1'b0; clear = 1'b0;
    waddr = '0; rsv_addr = '0; wdata = '0;
    for (int k = 0; k < 4; k++) ra[k] = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    int na, nb;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got a=%b b=%b, want 0", rdy_a, rdy_b);
    end
    rst_n = 1'b1;
    na = -1; nb = -1;
    for (int c = 1; c <= 100 && (na < 0 || nb < 0); c++) begin
      if (c == 5) begin
        we = 1'b1; waddr = 5'd3; wdata = 16'hABCD;
        ra[0] = 5'd3; ra[1] = 5'd7; ra[2] = 5'd0; ra[3] = 5'd31;
        for (int p = 0; p < 4; p++) exp_same("sweep_rd", p, 16'h0000, 1'b0);
        @(negedge clk);
        while (sb.size() != 0) begin
          e = sb.pop_front(); total++;
          if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
            bad++;
            $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                     e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
          end
        end
      end
      tick();
      we = 1'b0;
      if (rdy_a === 1'b1 && na < 0) na = c;
      if (rdy_b === 1'b1 && nb < 0) nb = c;
    end
    total++;
    if (na != 32 || nb != 32) begin
      bad++; $display("FAIL reset_latency: got a=%0d b=%0d cycles, want 32", na, nb);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      idle();
      ra[0] = AW'(a); ra[1] = AW'(a + 1); ra[2] = AW'(a + 1); ra[3] = AW'(a);
      for (int p = 0; p < 4; p++) exp_same("reset_rd", p, 16'h0000, 1'b0);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front(); total++;
        if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
          bad++;
          $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                   e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle();
      for (int k = 0; k < 4; k++) ra[k] = 5'd5;
      case (s)
        0: begin
          we = 1'b1; waddr = 5'd5; wdata = 16'hBEEF;
          for (int k = 0; k < 4; k++) ra[k] = 5'd9;
          for (int p = 0; p < 4; p++) exp_same("wr_other", p, 16'h0000, 1'b0);
        end
        1: for (int p = 0; p < 4; p++) exp_same("rd_after_wr", p, 16'hBEEF, 1'b0);
        2: begin
          we = 1'b1; waddr = 5'd5; wdata = 16'h1234;
          for (int p = 0; p < 4; p++) exp_same("bypass", p, 16'h1234, 1'b0);
        end
        default: for (int p = 0; p < 4; p++) exp_same("rd_after_bypass", p, 16'h1234, 1'b0);
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front(); total++;
        if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
          bad++;
          $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                   e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      idle();
      case (s)
        0: begin
          we = 1'b1; waddr = 5'd0; wdata = 16'hFFFF; rsv = 1'b1; rsv_addr = 5'd0;
          for (int p = 0; p < 4; p++) exp_rd("zero_wr", p, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        end
        1: for (int p = 0; p < 4; p++) exp_rd("zero_rd", p, 16'h0000, 1'b0, 16'hFFFF, 1'b1);
        default: begin
          we = 1'b1; waddr = 5'd0; wdata = 16'h0000;
          for (int p = 0; p < 4; p++) exp_rd("zero_restore", p, 16'h0000, 1'b0, 16'h0000, 1'b0);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front(); total++;
        if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
          bad++;
          $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                   e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
        end
      end
      tick();
    end
  endtask

  task automatic test_pending();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      idle();
      ra[0] = 5'd7; ra[1] = 5'd9;
      case (s)
        0: begin
          rsv = 1'b1; rsv_addr = 5'd7;
          exp_same("rsv_same_cyc", 0, 16'h0000, 1'b0);
        end
        1: exp_same("rsv_visible", 0, 16'h0000, 1'b1);
        2: begin
          we = 1'b1; waddr = 5'd7; wdata = 16'h00A5;
          exp_same("wr_resolves", 0, 16'h00A5, 1'b0);
        end
        3: exp_same("pend_cleared", 0, 16'h00A5, 1'b0);
        4: begin
          we = 1'b1; waddr = 5'd9; wdata = 16'h0909; rsv = 1'b1; rsv_addr = 5'd9;
          exp_same("rsv_wr_bypass", 1, 16'h0909, 1'b0);
        end
        default: begin
          exp_same("rsv_wins", 1, 16'h0909, 1'b1);
          exp_same("rsv_other", 0, 16'h00A5, 1'b0);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front(); total++;
        if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
          bad++;
          $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                   e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
        end
      end
      tick();
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int na, nb;
    logic [DW-1:0] v;
    for (int a = 1; a < DEPTH; a++) begin
      idle();
      v = 16'($urandom_range(1, 65535));
      we = 1'b1; waddr = AW'(a); wdata = v;
      model_mem[a] = v;
      tick();
    end
    idle(); rsv = 1'b1; rsv_addr = 5'd3;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        idle(); clear = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 16'hDEAD;
        tick();
        na = -1; nb = -1;
        for (int c = 1; c <= 100 && (na < 0 || nb < 0); c++) begin
          clear = 1'b0; we = 1'b1; waddr = AW'(c); wdata = 16'hDEAD; rsv = 1'b1; rsv_addr = AW'(c);
          tick();
          if (rdy_a === 1'b1 && na < 0) na = c;
          if (rdy_b === 1'b1 && nb < 0) nb = c;
        end
        total++;
        if (na != 32 || nb != 32) begin
          bad++; $display("FAIL clear_latency: got a=%0d b=%0d cycles, want 32", na, nb);
        end
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
      end
      for (int a = 0; a < DEPTH; a += 2) begin
        idle();
        ra[0] = AW'(a); ra[1] = AW'(a + 1); ra[2] = AW'(a + 1); ra[3] = AW'(a);
        exp_same("clear_rd", 0, model_mem[a], pass == 0 && a == 3);
        exp_same("clear_rd", 1, model_mem[a + 1], pass == 0 && a + 1 == 3);
        exp_same("clear_rd", 2, model_mem[a + 1], pass == 0 && a + 1 == 3);
        exp_same("clear_rd", 3, model_mem[a], pass == 0 && a == 3);
        @(negedge clk);
        while (sb.size() != 0) begin
          e = sb.pop_front(); total++;
          if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
            bad++;
            $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                     e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_midsweep();
    exp_t e;
    int na, nb;
    idle(); clear = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    na = -1; nb = -1;
    for (int c = 1; c <= 100 && (na < 0 || nb < 0); c++) begin
      tick();
      if (rdy_a === 1'b1 && na < 0) na = c;
      if (rdy_b === 1'b1 && nb < 0) nb = c;
    end
    total++;
    if (na != 32 || nb != 32) begin
      bad++; $display("FAIL midsweep_latency: got a=%0d b=%0d cycles, want 32", na, nb);
    end
    idle();
    for (int k = 0; k < 4; k++) ra[k] = AW'(k + 20);
    for (int p = 0; p < 4; p++) exp_same("midsweep_rd", p, 16'h0000, 1'b0);
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); total++;
      if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
        bad++;
        $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                 e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [DW-1:0] v;
    int o;
    for (int i = 1; i < DEPTH; i++) begin
      idle();
      v = 16'($urandom_range(1, 65535));
      o = (i + 15) % DEPTH;
      we = 1'b1; waddr = AW'(i); wdata = v;
      ra[0] = AW'(i - 1); ra[1] = AW'(i); ra[2] = AW'(i); ra[3] = AW'(o);
      exp_same("b2b_prev", 0, model_mem[i - 1], 1'b0);
      exp_same("b2b_bypass", 1, v, 1'b0);
      exp_same("b2b_bypass", 2, v, 1'b0);
      exp_same("b2b_other", 3, model_mem[o], 1'b0);
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front(); total++;
        if (obs_data(e.inst, e.port) !== e.data || obs_pend(e.inst, e.port) !== e.pend) begin
          bad++;
          $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b", e.name,
                   e.inst, e.port, obs_data(e.inst, e.port), obs_pend(e.inst, e.port), e.data, e.pend);
        end
      end
      tick();
      model_mem[i] = v;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_pending();
    test_clear();
    test_reset_midsweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
